logic_op_pipe: RTL and testbench
================================

// Module: logic_op_pipe
// PURPOSE
//   Parametrised, pipelined bitwise gate array: the successor to the fixed 1-bit NOR2B-style cells.
//   Applies a per-beat selectable two-input logic function, with optional input inversion, across
//   WIDTH bits, through STAGES register slices with valid/ready flow control.
//   Sits between AES datapath sub-blocks, e.g. AddRoundKey XOR and masking; it is not a library cell.
// PARAMETERS
//   WIDTH   128  operand/result bit width (>=1)
//   STAGES  2    number of register slices = latency in cycles (>=1)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input beat present
//   in_ready   out  1      block accepts beat this cycle
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_inv_a   in   1      1: invert A before op (NOR2B "AN" style)
//   in_inv_b   in   1      1: invert B before op
//   in_op      in   3      op code (op_e)
//   out_valid  out  1      result beat present
//   out_ready  in   1      downstream accepts result
//   out_y      out  WIDTH  result
//   busy       out  1      any slice holds a valid beat
// BEHAVIOUR
//   - Reset (async assert, sync-to-clk release): all slice valids=0, all data regs=0; out_valid=0,
//     out_y=0, busy=0; in_ready=1 from the first cycle after release. Reset mid-stream drops all beats.
//   - Operands: a'=in_a^{WIDTH{in_inv_a}}, b'=in_b^{WIDTH{in_inv_b}}. Op is computed combinationally
//     before slice 0; later slices only carry the result.
//   - op_e: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 PASS_A (y=a'), 7 PASS_B (y=b').
//     All 8 codes are legal and there is no error path.
//   - Transfer happens when valid&&ready on a given side. Latency is exactly STAGES cycles when out_ready=1.
//     Throughput is 1 beat/cycle.
//   - Slice k advances when: its next slice is empty, or its next slice advances. For the last slice,
//     "next slice advances" means out_ready.
//     Bubble-collapsing: an empty slice always loads, even while downstream stalls.
//   - in_ready = !v[0] || adv[0]. This is combinational from out_ready through the valid chain; there is
//     no in_valid->in_ready path.
//   - Capacity is STAGES beats. With out_ready=0, the block accepts exactly STAGES beats, then in_ready=0.
//   - While out_valid&&!out_ready, out_y must stay stable, and beat order is preserved.
//   - Simultaneous accept and emit when full with out_ready=1: in_ready=1, and occupancy is unchanged.
//   - busy = OR of slice valids.
//   - out_y = last slice data register, driven directly with no output logic.
//   - in_* fields are sampled only on an input handshake. X on in_a/in_b while in_valid=0 must not reach out_y.
// STRUCTURE
//   - logic_op_pkg: typedef enum logic [2:0] op_e {OP_AND..OP_PASS_B}; function logic_op_apply(a,b,op).
//   - Sub-module logic_op_stage #(WIDTH): one valid/data slice with ports up_valid, up_data, adv_in,
//     v_out, data_out, adv_out.
//     The top instantiates it STAGES times via generate and computes the combinational op.
// TESTING (WIDTH=8, STAGES=2 unless noted)
//   1 NOR2B equivalence: a=F0,b=3C,inv_a=1,op=NOR,out_ready=1 -> out_y=C0 exactly 2 cycles later.
//   2 Op sweep: a=A5,b=5A,inv=0, ops 0..7 back-to-back -> 00,FF,FF,00,FF,00,A5,5A in order,
//     one per cycle, with no bubbles.
//   3 Backpressure: out_ready=0, offer 3 beats -> 2 accepted, in_ready=0, busy=1.
//     Then out_ready=1 -> beats emerge in order, third accepted on the same cycle the first emits.
//   4 Stall hold: out_valid=1, out_ready=0 for 5 cycles -> out_y constant.
//     Bubble test: gap one cycle between inputs with out_ready=0 -> gap collapsed, both beats held.
//   5 Reset mid-op: 2 beats in flight, pulse rst_n low mid-cycle -> out_valid=0, busy=0, out_y=00
//     immediately; after release, first new beat has latency 2 and no stale data appears.
//   6 STAGES=1, WIDTH=1: random valid/ready for 10k cycles vs scoreboard -> zero mismatches,
//     and no in_ready/out_valid protocol violations.

Source files
------------

// File: rtl/logic_op_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : logic_op_pkg
//  Purpose  : Op-code enumeration and single-bit two-input logic function
//             shared by the logic_op_pipe datapath.
//  Revision : 1.0  initial release
// ============================================================================
package logic_op_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NOR    = 3'd3,
        OP_NAND   = 3'd4,
        OP_XNOR   = 3'd5,
        OP_PASS_A = 3'd6,
        OP_PASS_B = 3'd7
    } op_e;

    // One bit of the gate array; the top replicates it across the word.
    // Operands arrive already conditionally inverted.
    function automatic logic logic_op_apply(input logic a, input logic b, input op_e op);
        logic y;
        y = 1'b0;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NOR:    y = ~(a | b);
            OP_NAND:   y = ~(a & b);
            OP_XNOR:   y = ~(a ^ b);
            OP_PASS_A: y = a;
            OP_PASS_B: y = b;
        endcase
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_op_stage.sv
`default_nettype none
// ============================================================================
//  Module   : logic_op_stage
//  Purpose  : One valid/data register slice of the logic_op_pipe chain.
//             The slice loads whenever it is empty or its content moves on,
//             so bubbles collapse even while the output is stalled.
//  Revision : 1.0  initial release
// ============================================================================
module logic_op_stage
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             adv_in,
    output logic             v_out,
    output logic [WIDTH-1:0] data_out,
    output logic             adv_out
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_adv;

    // Slice may take a new beat if it is empty or its beat leaves this cycle.
    assign w_adv = !r_valid || adv_in;

    // Valid flag follows upstream whenever the slice advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (w_adv) begin
            r_valid <= up_valid;
        end
    end

    // Data only captured with a real beat, so idle-bus garbage never lands here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (w_adv && up_valid) begin
            r_data <= up_data;
        end
    end

    assign v_out    = r_valid;
    assign data_out = r_data;
    assign adv_out  = w_adv;

endmodule
`default_nettype wire

// File: rtl/logic_op_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : logic_op_pipe
//  Purpose  : Pipelined WIDTH-bit bitwise gate array with per-beat op select,
//             optional operand inversion and valid/ready flow control through
//             STAGES register slices (latency STAGES, 1 beat/cycle).
//  Revision : 1.0  initial release
// ============================================================================
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_inv_a,
    input  logic             in_inv_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             busy
);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_y;
    op_e              w_op;

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_adv;
    logic [WIDTH-1:0]  w_data [STAGES];

    // Operand conditioning; the op is resolved before slice 0 only.
    assign w_a  = in_a ^ {WIDTH{in_inv_a}};
    assign w_b  = in_b ^ {WIDTH{in_inv_b}};
    assign w_op = op_e'(in_op);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign w_y[i] = logic_op_apply(w_a[i], w_b[i], w_op);
        end
    endgenerate

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic             w_up_valid;
            logic [WIDTH-1:0] w_up_data;
            logic             w_adv_in;

            if (k == 0) begin : g_first
                assign w_up_valid = in_valid;
                assign w_up_data  = w_y;
            end else begin : g_rest
                assign w_up_valid = w_valid[k-1];
                assign w_up_data  = w_data[k-1];
            end

            // The last slice drains only when downstream takes the beat.
            if (k == STAGES - 1) begin : g_last
                assign w_adv_in = out_ready;
            end else begin : g_mid
                assign w_adv_in = w_adv[k+1];
            end

            logic_op_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .up_valid (w_up_valid),
                .up_data  (w_up_data),
                .adv_in   (w_adv_in),
                .v_out    (w_valid[k]),
                .data_out (w_data[k]),
                .adv_out  (w_adv[k])
            );
        end
    endgenerate

    // Ready depends only on the valid chain and out_ready, never on in_valid.
    assign in_ready  = w_adv[0];
    assign out_valid = w_valid[STAGES-1];
    assign out_y     = w_data[STAGES-1];
    assign busy      = |w_valid;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_op_pipe
//  Purpose  : Scoreboard bench for logic_op_pipe: WIDTH=8/STAGES=2 directed
//             vectors plus a WIDTH=1/STAGES=1 random valid/ready run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_op_pipe;

    typedef struct {
        logic [7:0] y;
        int         cyc;
        bit         lat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, in_inv_a, in_inv_b;
    logic [7:0] in_a, in_b;
    logic [2:0] in_op;
    logic       out_valid, out_ready, busy;
    logic [7:0] out_y;

    logic       u1_in_valid, u1_in_ready, u1_in_inv_a, u1_in_inv_b;
    logic [0:0] u1_in_a, u1_in_b, u1_out_y;
    logic [2:0] u1_in_op;
    logic       u1_out_valid, u1_out_ready, u1_busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   run6     = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    logic_op_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_inv_a(in_inv_a), .in_inv_b(in_inv_b),
        .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .busy(busy)
    );

    logic_op_pipe #(.WIDTH(1), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
        .in_a(u1_in_a), .in_b(u1_in_b), .in_inv_a(u1_in_inv_a), .in_inv_b(u1_in_inv_b),
        .in_op(u1_in_op), .out_valid(u1_out_valid), .out_ready(u1_out_ready),
        .out_y(u1_out_y), .busy(u1_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference for the random run.
    function automatic logic ref_bit(input logic a, input logic b, input logic ia,
                                     input logic ib, input logic [2:0] op);
        logic x, z;
        x = ia ? !a : a;
        z = ib ? !b : b;
        case (op)
            3'd0: return x && z;
            3'd1: return x || z;
            3'd2: return x != z;
            3'd3: return !(x || z);
            3'd4: return !(x && z);
            3'd5: return x == z;
            3'd6: return x;
            default: return z;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one beat (called just after a rising edge); expectation pushed on handshake.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ia,
                        input logic ib, input logic [2:0] op, input logic [7:0] exp,
                        input bit lat);
        in_a = a; in_b = b; in_inv_a = ia; in_inv_b = ib; in_op = op; in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb0.push_back('{y: exp, cyc: cyc + 2, lat: lat});
                @(posedge clk); #1;
                in_valid = 1'b0; in_a = 'x; in_b = 'x;
                return;
            end
            @(posedge clk); #1;
        end
        n_checks++; n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
        in_valid = 1'b0;
    endtask

    task automatic drain0();
        for (int t = 0; t < 30 && sb0.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain0_empty", sb0.size(), 0);
    endtask

    task automatic mon0();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_beat: got out_y=%0h expected no beat", out_y);
                end else begin
                    e = sb0.pop_front();
                    chk("out_y", out_y, e.y);
                    if (e.lat) chk("latency_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic mon1();
        exp_t e;
        bit   stall_prev = 0;
        logic prev_y     = 0;
        forever begin
            @(negedge clk);
            if (run6 && rst_n) begin
                chk("u1_in_ready", u1_in_ready, !u1_out_valid || u1_out_ready);
                if (stall_prev) begin
                    chk("u1_hold_valid", u1_out_valid, 1);
                    chk("u1_hold_y", u1_out_y, prev_y);
                end
                if (u1_out_valid && u1_out_ready) begin
                    if (sb1.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL u1_unexpected_beat: got %0h expected no beat", u1_out_y);
                    end else begin
                        e = sb1.pop_front();
                        chk("u1_out_y", u1_out_y, e.y);
                    end
                end
                stall_prev = u1_out_valid && !u1_out_ready;
                prev_y     = u1_out_y[0];
            end
        end
    endtask

    initial begin
        bit hold;
        rst_n = 1'b0; in_valid = 0; in_a = 0; in_b = 0; in_inv_a = 0; in_inv_b = 0;
        in_op = 0; out_ready = 1;
        u1_in_valid = 0; u1_in_a = 0; u1_in_b = 0; u1_in_inv_a = 0; u1_in_inv_b = 0;
        u1_in_op = 0; u1_out_ready = 1;
        fork
            mon0();
            mon1();
        join_none

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_y", out_y, 8'h00);
        chk("rst_in_ready", in_ready, 1);

        // 1: NOR2B equivalence, latency 2
        send(8'hF0, 8'h3C, 1, 0, 3'd3, 8'hC0, 1);
        drain0();

        // 2: op sweep back-to-back, one per cycle
        @(posedge clk); #1;
        send(8'hA5, 8'h5A, 0, 0, 3'd0, 8'h00, 1);
        send(8'hA5, 8'h5A, 0, 0, 3'd1, 8'hFF, 1);
        send(8'hA5, 8'h5A, 0, 0, 3'd2, 8'hFF, 1);
        send(8'hA5, 8'h5A, 0, 0, 3'd3, 8'h00, 1);
        send(8'hA5, 8'h5A, 0, 0, 3'd4, 8'hFF, 1);
        send(8'hA5, 8'h5A, 0, 0, 3'd5, 8'h00, 1);
        send(8'hA5, 8'h5A, 0, 0, 3'd6, 8'hA5, 1);
        send(8'hA5, 8'h5A, 0, 0, 3'd7, 8'h5A, 1);
        drain0();

        // 3: backpressure, capacity 2, simultaneous accept/emit
        @(posedge clk); #1;
        out_ready = 0;
        send(8'h12, 8'h34, 0, 0, 3'd2, 8'h26, 0);
        send(8'hFF, 8'h0F, 0, 1, 3'd0, 8'hF0, 0);
        in_a = 8'h55; in_b = 8'h00; in_inv_a = 1; in_inv_b = 0; in_op = 3'd1; in_valid = 1;
        repeat (2) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            chk("full_busy", busy, 1);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(negedge clk);
        chk("accept_emit_in_ready", in_ready, 1);
        chk("accept_emit_out_valid", out_valid, 1);
        sb0.push_back('{y: 8'hAA, cyc: 0, lat: 0});
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("occupancy_out_valid", out_valid, 1);
        chk("occupancy_busy", busy, 1);
        drain0();

        // 4: bubble collapse and stall hold
        @(posedge clk); #1;
        out_ready = 0;
        send(8'h81, 8'h18, 0, 0, 3'd1, 8'h99, 0);
        @(posedge clk); #1;
        send(8'h0F, 8'hFF, 0, 0, 3'd4, 8'hF0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_y", out_y, 8'h99);
            chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1;
        drain0();

        // 5: reset mid-stream
        @(posedge clk); #1;
        out_ready = 0;
        send(8'h11, 8'h22, 0, 0, 3'd2, 8'h33, 0);
        send(8'h44, 8'h44, 0, 0, 3'd5, 8'hFF, 0);
        @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_y", out_y, 8'h00);
        sb0.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1;
        send(8'hC3, 8'h3C, 0, 1, 3'd7, 8'hC3, 1);
        drain0();

        // 6: WIDTH=1, STAGES=1 random valid/ready
        @(posedge clk); #1;
        run6 = 1;
        hold = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!hold) begin
                u1_in_valid = 1'($urandom_range(0, 1));
                u1_in_a     = 1'($urandom_range(0, 1));
                u1_in_b     = 1'($urandom_range(0, 1));
                u1_in_inv_a = 1'($urandom_range(0, 1));
                u1_in_inv_b = 1'($urandom_range(0, 1));
                u1_in_op    = 3'($urandom_range(0, 7));
            end
            u1_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (u1_in_valid && u1_in_ready) begin
                sb1.push_back('{y: {7'd0, ref_bit(u1_in_a[0], u1_in_b[0], u1_in_inv_a,
                                                 u1_in_inv_b, u1_in_op)},
                                cyc: 0, lat: 0});
                hold = 0;
            end else begin
                hold = u1_in_valid;
            end
            @(posedge clk); #1;
        end
        u1_in_valid  = 0;
        u1_out_ready = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("u1_drain_empty", sb1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
